// File: rtl/framebuffer_scanout_pkg.sv
// Shared constants and types for the framebuffer scan-out path.
// Stored image geometry, BRAM address width, colour and swap-FSM types.
// The helper returns the base address of a front buffer.
package framebuffer_scanout_pkg;
    localparam int FRAME_WIDTH  = 512;
    localparam int FRAME_HEIGHT = 384;
    localparam int ADDR_BITS    = 19;
    localparam int W_SHIFT      = $clog2(FRAME_WIDTH);
    localparam int FB_PIXELS    = FRAME_WIDTH * FRAME_HEIGHT;

    typedef logic [11:0] rgb12_t;

    typedef enum logic [0:0] {
        SWAP_IDLE,
        SWAP_PENDING
    } swap_state_t;

    // Buffer 0 starts at address 0, buffer 1 directly after it.
    function automatic logic [ADDR_BITS-1:0] buf_base(input logic fb);
        return fb ? ADDR_BITS'(FB_PIXELS) : '0;
    endfunction
endpackage

// File: rtl/framebuffer_scanout_if.sv
// Signal bundle between the VGA timing/BRAM/pins side and the scan-out block.
// master = timing generator, BRAM and pins; slave = framebuffer_scanout.
// No flow control: every signal is sampled or driven once per pixel clock.
interface framebuffer_scanout_if;
    import framebuffer_scanout_pkg::*;

    logic [15:0]          hcount_in;
    logic [15:0]          vcount_in;
    logic                 hsync_in;
    logic                 vsync_in;
    logic                 blank_in;
    rgb12_t               border_color;
    logic                 swap_req;
    logic                 swap_ack;
    logic                 front_buf;
    logic                 frame_start;
    logic [ADDR_BITS-1:0] bram_addr;
    logic [15:0]          bram_dout;
    logic [3:0]           vga_r;
    logic [3:0]           vga_g;
    logic [3:0]           vga_b;
    logic                 vga_hs;
    logic                 vga_vs;

    modport master (
        output hcount_in, vcount_in, hsync_in, vsync_in, blank_in,
        output border_color, swap_req, bram_dout,
        input  swap_ack, front_buf, frame_start, bram_addr,
        input  vga_r, vga_g, vga_b, vga_hs, vga_vs
    );

    modport slave (
        input  hcount_in, vcount_in, hsync_in, vsync_in, blank_in,
        input  border_color, swap_req, bram_dout,
        output swap_ack, front_buf, frame_start, bram_addr,
        output vga_r, vga_g, vga_b, vga_hs, vga_vs
    );
endinterface

// File: rtl/framebuffer_scanout_pipe.sv
// Fixed-length shift register delaying a small bundle of control bits.
// Latency LENGTH cycles; async reset loads every stage with RST_VAL.
// No backpressure: shifts on every clock.
module framebuffer_scanout_pipe #(
    parameter int               LENGTH  = 3,
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_dat,
    output logic [WIDTH-1:0] o_dat
);
    logic [WIDTH-1:0] r_stage [LENGTH];

    // Shift the bundle one stage per clock; reset flushes all stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LENGTH; i++) r_stage[i] <= RST_VAL;
        end else begin
            r_stage[0] <= i_dat;
            for (int i = 1; i < LENGTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_dat = r_stage[LENGTH-1];
endmodule

// File: rtl/framebuffer_scanout.sv
// Framebuffer read side: VGA coords -> upscaled BRAM address, sync realignment, RGB pins.
// Latency: address 1 cycle after coords; colour/syncs 1+READ_LATENCY cycles after coords.
// No backpressure; double-buffer front select swaps only on a vsync rising edge.
module framebuffer_scanout
    import framebuffer_scanout_pkg::*;
#(
    parameter int SCALE_SHIFT  = 1,
    parameter int READ_LATENCY = 2
) (
    input logic                  clk,
    input logic                  rst,
    framebuffer_scanout_if.slave bus
);
    localparam int L = 1 + READ_LATENCY;

    logic [15:0]          w_sx;
    logic [15:0]          w_sy;
    logic                 w_in_img;
    logic [ADDR_BITS-1:0] w_base;
    logic [ADDR_BITS-1:0] w_addr;
    logic [ADDR_BITS-1:0] r_bram_addr;
    logic                 r_front_buf;
    logic                 r_swap_ack;
    logic                 r_frame_start;
    logic                 r_vsync_prev;
    swap_state_t          r_state;
    swap_state_t          w_state_nxt;
    logic                 w_do_swap;
    logic                 w_vs_rise;
    logic [3:0]           w_dly;
    logic                 w_hs_d;
    logic                 w_vs_d;
    logic                 w_blank_d;
    logic                 w_in_img_d;
    rgb12_t               w_pix;
    logic [3:0]           w_unused_dout;

    // Stage A address: stored pixel = display pixel scaled down; outside the image the
    // address parks on the buffer base (the colour is replaced by the border later).
    always_comb begin
        w_sx     = bus.hcount_in >> SCALE_SHIFT;
        w_sy     = bus.vcount_in >> SCALE_SHIFT;
        w_in_img = (w_sx < 16'(FRAME_WIDTH)) && (w_sy < 16'(FRAME_HEIGHT));
        w_base   = buf_base(r_front_buf);
        w_addr   = w_base;
        if (w_in_img) begin
            w_addr = w_base + (ADDR_BITS'(w_sy) << W_SHIFT) + ADDR_BITS'(w_sx);
        end
    end

    // Register the BRAM address and the start-of-frame pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bram_addr   <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_bram_addr   <= w_addr;
            r_frame_start <= (bus.hcount_in == 16'd0) && (bus.vcount_in == 16'd0);
        end
    end

    assign w_vs_rise = bus.vsync_in && !r_vsync_prev;

    // Swap request is applied on the first vsync rising edge, including one in the
    // same cycle as the request; repeated requests while pending collapse into one.
    always_comb begin
        w_state_nxt = r_state;
        w_do_swap   = 1'b0;
        case (r_state)
            SWAP_IDLE: begin
                if (bus.swap_req) begin
                    if (w_vs_rise) w_do_swap   = 1'b1;
                    else           w_state_nxt = SWAP_PENDING;
                end
            end
            SWAP_PENDING: begin
                if (w_vs_rise) begin
                    w_do_swap   = 1'b1;
                    w_state_nxt = SWAP_IDLE;
                end
            end
            default: w_state_nxt = SWAP_IDLE;
        endcase
    end

    // Swap state, front buffer select, ack pulse and vsync edge history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= SWAP_IDLE;
            r_front_buf  <= 1'b0;
            r_swap_ack   <= 1'b0;
            r_vsync_prev <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_front_buf  <= r_front_buf ^ w_do_swap;
            r_swap_ack   <= w_do_swap;
            r_vsync_prev <= bus.vsync_in;
        end
    end

    // Control bits travel alongside the BRAM read so they meet bram_dout of the same pixel.
    framebuffer_scanout_pipe #(
        .LENGTH  (L),
        .WIDTH   (4),
        .RST_VAL (4'b0010)
    ) u_pipe (
        .clk   (clk),
        .rst   (rst),
        .i_dat ({bus.hsync_in, bus.vsync_in, bus.blank_in, w_in_img}),
        .o_dat (w_dly)
    );

    assign {w_hs_d, w_vs_d, w_blank_d, w_in_img_d} = w_dly;
    assign w_unused_dout = bus.bram_dout[15:12];

    // Final colour select is driven from the last pipe stage, so it lands in the same
    // cycle as bram_dout and the delayed syncs.
    always_comb begin
        w_pix = '0;
        if (!w_blank_d) begin
            w_pix = w_in_img_d ? rgb12_t'(bus.bram_dout[11:0]) : bus.border_color;
        end
    end

    assign bus.bram_addr   = r_bram_addr;
    assign bus.frame_start = r_frame_start;
    assign bus.front_buf   = r_front_buf;
    assign bus.swap_ack    = r_swap_ack;
    assign bus.vga_r       = w_pix[11:8];
    assign bus.vga_g       = w_pix[7:4];
    assign bus.vga_b       = w_pix[3:0];
    assign bus.vga_hs      = ~w_hs_d;
    assign bus.vga_vs      = ~w_vs_d;
endmodule

// File: tb/tb_framebuffer_scanout.sv
// Testbench for framebuffer_scanout: directed literal checks plus randomized traffic
// compared each cycle against a pixel-level reference model of the scan-out rules.
module tb_framebuffer_scanout;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    framebuffer_scanout_if bus();

    framebuffer_scanout #(
        .SCALE_SHIFT  (1),
        .READ_LATENCY (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // BRAM model: two-cycle addr->dout, content = low 12 address bits, junk in [15:12].
    logic [18:0] bq1, bq2;
    always @(posedge clk) begin
        bq1 <= bus.bram_addr;
        bq2 <= bq1;
    end
    assign bus.bram_dout = {4'hF, bq2[11:0]};

    typedef struct {
        bit          hs;
        bit          vs;
        bit          bl;
        bit          in_img;
        bit          zero;
        bit          ack;
        int          addr;
        logic [11:0] border;
    } rec_t;

    rec_t        hist [8192];
    int          tests = 0;
    int          fails = 0;
    int          n = 0;
    int          live_from = 0;
    int          m_fb = 0;
    bit          m_pend = 0;
    bit          m_vsprev = 0;
    logic [11:0] cur_border = 12'h0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at edge %0d: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, n, act, act, exp, exp);
        end
    endtask

    // Reference: what the pins must show right after edge n.
    task automatic compare();
        rec_t r;
        rec_t p;
        int   j;
        int   col;
        int   ehs;
        int   evs;
        r = hist[n];
        chk("bram_addr", int'(bus.bram_addr), r.addr);
        chk("frame_start", int'(bus.frame_start), int'(r.zero));
        chk("front_buf", int'(bus.front_buf), m_fb);
        chk("swap_ack", int'(bus.swap_ack), int'(r.ack));
        j = n - 2;
        col = 0;
        ehs = 1;
        evs = 1;
        if (j >= live_from) begin
            p = hist[j];
            ehs = p.hs ? 0 : 1;
            evs = p.vs ? 0 : 1;
            if (!p.bl) col = p.in_img ? (p.addr % 4096) : int'(r.border);
        end
        chk("rgb", int'({bus.vga_r, bus.vga_g, bus.vga_b}), col);
        chk("vga_hs", int'(bus.vga_hs), ehs);
        chk("vga_vs", int'(bus.vga_vs), evs);
    endtask

    // Apply one pixel clock of inputs, advance the model, clock, and compare.
    task automatic cyc(input int h, input int v, input bit hs, input bit vs,
                       input bit bl, input bit req);
        rec_t r;
        int   sx;
        int   sy;
        bus.hcount_in    = 16'(h);
        bus.vcount_in    = 16'(v);
        bus.hsync_in     = hs;
        bus.vsync_in     = vs;
        bus.blank_in     = bl;
        bus.swap_req     = req;
        bus.border_color = cur_border;
        sx = h / 2;
        sy = v / 2;
        r.hs     = hs;
        r.vs     = vs;
        r.bl     = bl;
        r.border = cur_border;
        r.in_img = (sx < 512) && (sy < 384);
        r.addr   = m_fb * 512 * 384 + (r.in_img ? sy * 512 + sx : 0);
        r.zero   = (h == 0) && (v == 0);
        r.ack    = 1'b0;
        if (vs && !m_vsprev && (m_pend || req)) begin
            m_fb   = 1 - m_fb;
            m_pend = 1'b0;
            r.ack  = 1'b1;
        end else if (req) begin
            m_pend = 1'b1;
        end
        m_vsprev = vs;
        hist[n+1] = r;
        @(posedge clk);
        #1;
        n++;
        compare();
    endtask

    // Assert reset away from a clock edge, check outputs before any edge, hold, release.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_addr", int'(bus.bram_addr), 0);
        chk("rst_rgb", int'({bus.vga_r, bus.vga_g, bus.vga_b}), 0);
        chk("rst_hs", int'(bus.vga_hs), 1);
        chk("rst_vs", int'(bus.vga_vs), 1);
        chk("rst_ack", int'(bus.swap_ack), 0);
        chk("rst_fb", int'(bus.front_buf), 0);
        chk("rst_fs", int'(bus.frame_start), 0);
        m_fb     = 0;
        m_pend   = 1'b0;
        m_vsprev = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            n++;
        end
        rst = 1'b0;
        live_from = n + 1;
    endtask

    initial begin
        bus.hcount_in    = '0;
        bus.vcount_in    = '0;
        bus.hsync_in     = 1'b0;
        bus.vsync_in     = 1'b0;
        bus.blank_in     = 1'b1;
        bus.swap_req     = 1'b0;
        bus.border_color = '0;
        do_reset();

        // Scaling and pipeline alignment.
        cyc(10, 6, 0, 0, 0, 0);
        chk("lit_addr_10_6", int'(bus.bram_addr), 1541);
        cyc(12, 6, 1, 0, 0, 0);
        cyc(14, 6, 1, 0, 0, 0);
        chk("lit_rgb_align", int'({bus.vga_r, bus.vga_g, bus.vga_b}), 12'h605);
        chk("lit_hs_not_yet", int'(bus.vga_hs), 1);
        cyc(16, 6, 0, 0, 0, 0);
        chk("lit_hs_low", int'(bus.vga_hs), 0);

        // Border and blanking.
        cur_border = 12'hF00;
        repeat (3) cyc(1100, 6, 0, 0, 0, 0);
        chk("lit_border_r", int'(bus.vga_r), 15);
        chk("lit_border_gb", int'({bus.vga_g, bus.vga_b}), 0);
        repeat (3) cyc(1100, 6, 0, 0, 1, 0);
        chk("lit_blank", int'({bus.vga_r, bus.vga_g, bus.vga_b}), 0);

        // Swap waits for vsync rising edge.
        cyc(100, 100, 0, 0, 0, 1);
        repeat (4) cyc(102, 100, 0, 0, 0, 0);
        chk("lit_fb_wait", int'(bus.front_buf), 0);
        cyc(0, 770, 0, 1, 1, 0);
        chk("lit_fb_swapped", int'(bus.front_buf), 1);
        chk("lit_ack_pulse", int'(bus.swap_ack), 1);
        cyc(2, 770, 0, 1, 1, 0);
        chk("lit_ack_done", int'(bus.swap_ack), 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("lit_addr_buf1", int'(bus.bram_addr), 196608);
        chk("lit_frame_start", int'(bus.frame_start), 1);

        // Two requests before vsync -> single toggle; request on the edge cycle -> immediate.
        cyc(4, 4, 0, 0, 0, 1);
        cyc(6, 4, 0, 0, 0, 1);
        cyc(8, 4, 0, 0, 0, 0);
        cyc(0, 770, 0, 1, 1, 0);
        chk("lit_double_one", int'(bus.front_buf), 0);
        cyc(2, 770, 0, 1, 1, 0);
        chk("lit_double_stay", int'(bus.front_buf), 0);
        cyc(4, 770, 0, 0, 1, 0);
        cyc(0, 771, 0, 1, 1, 1);
        chk("lit_same_cycle_fb", int'(bus.front_buf), 1);
        chk("lit_same_cycle_ack", int'(bus.swap_ack), 1);

        // Reset while a request is pending drops it.
        cyc(4, 10, 0, 0, 0, 0);
        cyc(6, 10, 0, 0, 0, 1);
        do_reset();
        cyc(8, 10, 0, 0, 0, 0);
        cyc(0, 770, 0, 1, 1, 0);
        chk("lit_no_ack_after_rst", int'(bus.swap_ack), 0);
        chk("lit_fb_after_rst", int'(bus.front_buf), 0);

        // Randomized traffic against the model, with one reset in the middle.
        begin
            bit rvs = 1'b0;
            bit rhs = 1'b0;
            for (int i = 0; i < 1500; i++) begin
                if (i == 700) do_reset();
                if ((i % 64) == 0) cur_border = 12'($urandom);
                if ($urandom_range(0, 7) == 0) rvs = ~rvs;
                if ($urandom_range(0, 5) == 0) rhs = ~rhs;
                cyc($urandom_range(0, 1279), $urandom_range(0, 899), rhs, rvs,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
